instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit sitting directly upstream of the processor's `iin` port. It sequences a program counter through a synchronous instruction ROM and presents one 16-bit instruction word on `iin`, holding it stable until the processor signals completion. A one-entry prefetch buffer hides ROM latency, so back-to-back instructions issue without bubbles. A reserved halt word stops fetching.

## Interface
- `ADDR_W`, 8: ROM address width; the PC wraps modulo 2^ADDR_W.
- `DATA_W`, 16: instruction width; must equal the processor `iin` width.
- `HALT_WORD`, 16'hFFFF: fetched word that stops fetching and is never presented.

- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `run` in 1: fetch enable, sampled in IDLE and on `done`.
- `done` in 1: one-cycle pulse from the processor control unit (its counter-clear event) meaning the current instruction has retired.
- `mem_en` out 1: ROM read strobe.
- `mem_addr` out ADDR_W: ROM read address.
- `mem_rdata` in DATA_W: ROM data, valid exactly one cycle after `mem_en`.
- `iin` out DATA_W: instruction to the processor.
- `iin_valid` out 1: `iin` holds a live instruction.
- `pc` out ADDR_W: next address to request.
- `halted` out 1: halt word reached.

## Operation
- States: IDLE, REQ, LOAD, HOLD, HALT. Reset puts the block in IDLE with `pc`=0, `iin`=0, `iin_valid`=0, `halted`=0, prefetch empty, `mem_en`=0, and `mem_addr`=0.
- `mem_en` and `mem_addr` are combinational from the state and `pc`. Every request increments `pc`, with wrap from 2^ADDR_W−1 to 0.
- IDLE: when `run`=1, go to REQ. Otherwise stay in IDLE.
- REQ: assert `mem_en`, drive `mem_addr`=`pc`, then go to LOAD.
- LOAD: capture `mem_rdata` into `iin`.
  - If the word equals HALT_WORD, go to HALT with `iin_valid`=0.
  - Otherwise set `iin_valid`=1 and go to HOLD.
- HOLD: `iin` is stable.
  - If the prefetch buffer is empty, no prefetch is in flight, and `run`=1, issue a prefetch: `mem_en`=1, addr=`pc`.
  - The returning data is written into the buffer one cycle later.
- `done` in HOLD, in priority order:
  - `run`=0: go to IDLE with `iin_valid`=0. Discard the buffer and any in-flight data. Rewind `pc` by 1 if a prefetch was buffered or in flight.
  - Buffer valid: move the buffer into `iin` and clear the buffer; stay in HOLD.
  - Prefetch data returning in this same cycle: bypass `mem_rdata` into `iin`; stay in HOLD.
  - Prefetch issued in this same cycle: go to LOAD, with `iin_valid`=0 for that LOAD cycle.
- Any word moved into `iin` that equals HALT_WORD takes the block to HALT instead, with `iin_valid`=0.
- HALT: `halted`=1, `iin_valid`=0, `mem_en`=0. Only `resetn` leaves HALT.
- `done` outside HOLD is ignored.
- `resetn` low mid-operation clears everything immediately, including any in-flight read. The ROM data returned after reset is ignored.

## Timing
- Cold start: `run`=1 sampled in IDLE at edge k gives REQ after edge k, LOAD after edge k+1, and `iin_valid`=1 after edge k+2. First-instruction latency is 3 cycles.
- Steady state: `done` at edge n (buffer valid) gives the new `iin` after edge n, with zero bubble cycles.
- Minimum instruction length for bubble-free issue is 2 cycles in HOLD. `done` on the first HOLD cycle costs one bubble (LOAD).
- `iin` changes only on a clock edge and never while `iin_valid`=1 without a `done`.
- At most one ROM read is outstanding; the buffer depth is 1.

## Structure
- Package `fetch_pkg` holds:
  - the state enum: IDLE, REQ, LOAD, HOLD, HALT;
  - the HALT_WORD default;
  - the DATA_W default of 16, shared with the processor.
- One sub-module, `prefetch_reg`: a one-entry buffer with `load`, `clear`, `valid`, and `data` signals, plus a `pending` flag for the in-flight read.
- The FSM and PC stay in `instr_fetch`.

## Test plan
- Reset, then `run`=1 with ROM[0]=16'h1234 → `iin_valid` rises 3 cycles after `run` is sampled; `iin`=16'h1234 and `pc`=2 once the prefetch is issued.
- ROM[0..3]=16'h0001..16'h0004, with `done` every 3 cycles → `iin` steps 1, 2, 3, 4 with `iin_valid` never dropping.
- `done` pulsed on the first HOLD cycle every time → exactly one LOAD bubble per instruction (`iin_valid`=0 for 1 cycle); no word is skipped or duplicated.
- ROM[2]=16'hFFFF → after instruction 1 retires, `halted`=1, `iin_valid`=0, and `mem_en` stays 0 for 20 cycles.
- `run` dropped before `done` with the buffer full at `pc`=3 → IDLE with `pc`=2; re-asserting `run` fetches ROM[2] first.
- `pc` starting at 255 (ADDR_W=8) → the next request is to address 0. Also: `resetn` pulsed low during LOAD → all outputs return to their reset values immediately, and the stale `mem_rdata` is not captured.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared state encoding and defaults for the instruction fetch unit.
// DATA_W_DEF is shared with the processor so both sides agree on the iin width.
package fetch_pkg;

    localparam int DATA_W_DEF = 16;
    localparam logic [DATA_W_DEF-1:0] HALT_WORD_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_LOAD = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_prefetch_reg.sv
// One-entry prefetch buffer plus the flag for the single in-flight ROM read.
// A clear drops both the buffered word and any read still outstanding.
module prefetch_reg
    import fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              pend_set_i,
    input  logic              pend_clr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              pending_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              pending_q;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            pending_q <= 1'b0;
        end else if (clear_i) begin
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            if (load_i) begin
                valid_q <= 1'b1;
                data_q  <= data_i;
            end
            if (pend_set_i) begin
                pending_q <= 1'b1;
            end else if (pend_clr_i) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the PC through a synchronous ROM and holds one
// instruction on iin until the processor retires it, with a one-word prefetch.
//
// state | meaning
// IDLE  | waiting for run
// REQ   | ROM read issued for pc
// LOAD  | ROM word lands in iin
// HOLD  | iin live; prefetch next word into the buffer
// HALT  | halt word fetched; only reset leaves
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
)(
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] iin,
    output logic              iin_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] iin_q, iin_d;
    logic              iin_valid_q, iin_valid_d;

    logic              pf_valid;
    logic              pf_pending;
    logic [DATA_W-1:0] pf_data;
    logic              pf_load;
    logic              pf_clear;
    logic              pf_set;
    logic              pf_clr;
    logic              issue;

    prefetch_reg #(
        .DATA_W (DATA_W)
    ) u_prefetch (
        .clock_i    (clock),
        .resetn_i   (resetn),
        .load_i     (pf_load),
        .clear_i    (pf_clear),
        .pend_set_i (pf_set),
        .pend_clr_i (pf_clr),
        .data_i     (mem_rdata),
        .valid_o    (pf_valid),
        .data_o     (pf_data),
        .pending_o  (pf_pending)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            iin_q       <= '0;
            iin_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            iin_q       <= iin_d;
            iin_valid_q <= iin_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        iin_d       = iin_q;
        iin_valid_d = iin_valid_q;
        mem_en      = 1'b0;
        mem_addr    = '0;
        pf_load     = 1'b0;
        pf_clear    = 1'b0;
        pf_set      = 1'b0;
        pf_clr      = 1'b0;
        issue       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                mem_en   = 1'b1;
                mem_addr = pc_q;
                pc_d     = pc_q + PC_STEP;
                state_d  = ST_LOAD;
            end

            ST_LOAD: begin
                iin_d = mem_rdata;
                if (mem_rdata == HALT_WORD) begin
                    state_d     = ST_HALT;
                    iin_valid_d = 1'b0;
                end else begin
                    state_d     = ST_HOLD;
                    iin_valid_d = 1'b1;
                end
            end

            ST_HOLD: begin
                issue = run && !pf_valid && !pf_pending;
                if (issue) begin
                    mem_en   = 1'b1;
                    mem_addr = pc_q;
                    pc_d     = pc_q + PC_STEP;
                end

                if (done) begin
                    if (!run) begin
                        // Abandon the prefetch so the next run refetches that word.
                        state_d     = ST_IDLE;
                        iin_valid_d = 1'b0;
                        pf_clear    = 1'b1;
                        if (pf_valid || pf_pending) begin
                            pc_d = pc_q - PC_STEP;
                        end
                    end else if (pf_valid) begin
                        pf_clear = 1'b1;
                        iin_d    = pf_data;
                        if (pf_data == HALT_WORD) begin
                            state_d     = ST_HALT;
                            iin_valid_d = 1'b0;
                        end
                    end else if (pf_pending) begin
                        pf_clr = 1'b1;
                        iin_d  = mem_rdata;
                        if (mem_rdata == HALT_WORD) begin
                            state_d     = ST_HALT;
                            iin_valid_d = 1'b0;
                        end
                    end else begin
                        // Read issued this cycle; LOAD captures it directly.
                        state_d     = ST_LOAD;
                        iin_valid_d = 1'b0;
                    end
                end else begin
                    pf_set = issue;
                    if (pf_pending) begin
                        pf_load = 1'b1;
                        pf_clr  = 1'b1;
                    end
                end
            end

            ST_HALT: begin
                iin_valid_d = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                iin_valid_d = 1'b0;
            end
        endcase
    end

    assign iin       = iin_q;
    assign iin_valid = iin_valid_q;
    assign pc        = pc_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected instruction stream is queued from
// the program image; a monitor pops and compares each instruction presented.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        resetn;
    logic        run;
    logic        done;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [15:0] iin;
    logic        iin_valid;
    logic [7:0]  pc;
    logic        halted;

    always #5 clock = ~clock;

    instr_fetch #(
        .ADDR_W    (8),
        .DATA_W    (16),
        .HALT_WORD (16'hFFFF)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .run       (run),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .iin       (iin),
        .iin_valid (iin_valid),
        .pc        (pc),
        .halted    (halted)
    );

    logic [15:0] rom [256];
    always @(posedge clock) if (mem_en) mem_rdata <= rom[mem_addr];

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    bit auto_done  = 1'b0;
    bit man_done   = 1'b0;
    int tgt_fix    = 0;
    bit chk_req    = 1'b0;
    int req_next   = 0;
    int bub_cnt    = 0;
    bit seen_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == 16'hFFFF) w = 16'h0F0F;
        return w;
    endfunction

    // processor model: retire each instruction after tgt HOLD cycles
    initial begin : drv
        bit pv;
        bit nw;
        int hc;
        int tgt;
        done = 1'b0;
        pv = 1'b0;
        hc = 0;
        tgt = 1;
        forever begin
            @(posedge clock);
            #1;
            if (!auto_done) begin
                done = man_done;
            end else begin
                nw = iin_valid && (!pv || done);
                if (nw) begin
                    hc = 1;
                    tgt = (tgt_fix > 0) ? tgt_fix : int'($urandom_range(4, 1));
                end else if (iin_valid) begin
                    hc++;
                end
                done = iin_valid && (hc >= tgt);
            end
            pv = iin_valid;
        end
    end

    initial begin : mon
        bit lv;
        bit ld;
        logic [15:0] li;
        logic [15:0] e;
        lv = 1'b0;
        ld = 1'b0;
        li = '0;
        forever begin
            @(negedge clock);
            if (iin_valid && (!lv || ld)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr actual=%0h required=none", iin);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_word", {16'h0, iin}, {16'h0, e});
                end
            end else if (iin_valid && lv) begin
                check("iin_stable", {16'h0, iin}, {16'h0, li});
            end
            if (seen_valid && !iin_valid && !halted) bub_cnt++;
            if (iin_valid) seen_valid = 1'b1;
            lv = iin_valid;
            ld = done;
            li = iin;
        end
    end

    initial begin : reqmon
        forever begin
            @(negedge clock);
            if (chk_req && mem_en) begin
                check("req_addr", {24'h0, mem_addr}, 32'(req_next));
                req_next = (req_next + 1) % 256;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        run       = 1'b0;
        auto_done = 1'b0;
        man_done  = 1'b0;
        tgt_fix   = 0;
        chk_req   = 1'b0;
        exp_q.delete();
        tick(2);
        resetn = 1'b1;
        tick(1);
        seen_valid = 1'b0;
        bub_cnt    = 0;
    endtask

    task automatic pulse_done();
        @(negedge clock);
        man_done = 1'b1;
        @(negedge clock);
        man_done = 1'b0;
    endtask

    task automatic end_scn(input string name, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, {31'h0, halted}, 32'h1);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin : main
        int n;
        resetn = 1'b0;
        run    = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = rnd_word();
        #12;
        check("rst_pc", {24'h0, pc}, 32'h0);
        check("rst_iin", {16'h0, iin}, 32'h0);
        check("rst_valid", {31'h0, iin_valid}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
        tick(1);
        resetn = 1'b1;
        tick(1);

        // cold-start latency
        rom[0] = 16'h1234;
        rom[1] = 16'hFFFF;
        exp_q.push_back(16'h1234);
        @(posedge clock); #1;
        run = 1'b1;
        @(posedge clock); #1;
        check("lat_edge_k", {31'h0, iin_valid}, 32'h0);
        @(posedge clock); #1;
        check("lat_edge_k1", {31'h0, iin_valid}, 32'h0);
        @(posedge clock); #1;
        check("lat_edge_k2", {31'h0, iin_valid}, 32'h1);
        check("lat_iin", {16'h0, iin}, 32'h1234);
        @(posedge clock); #1;
        check("lat_pc", {24'h0, pc}, 32'h2);
        pulse_done();
        end_scn("halt_cold", 50);

        // done every 3 cycles: zero bubbles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rom[i] = 16'(i + 1);
            exp_q.push_back(16'(i + 1));
        end
        rom[4] = 16'hFFFF;
        tgt_fix = 3; auto_done = 1'b1;
        run = 1'b1;
        end_scn("halt_t3", 100);
        check("bubbles_t3", 32'(bub_cnt), 32'h0);

        // done on first HOLD cycle: one bubble per instruction
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rom[i] = rnd_word();
            exp_q.push_back(rom[i]);
        end
        rom[5] = 16'hFFFF;
        tgt_fix = 1; auto_done = 1'b1;
        run = 1'b1;
        end_scn("halt_t1", 100);
        check("bubbles_t1", 32'(bub_cnt), 32'h5);

        // halt word at address 2, reached through the bypass path
        do_reset();
        rom[0] = 16'hA001; rom[1] = 16'hA002; rom[2] = 16'hFFFF;
        exp_q.push_back(16'hA001);
        exp_q.push_back(16'hA002);
        tgt_fix = 2; auto_done = 1'b1;
        run = 1'b1;
        end_scn("halt_word", 100);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("halt_mem_en", {31'h0, mem_en}, 32'h0);
        end
        check("halt_valid", {31'h0, iin_valid}, 32'h0);

        // run dropped with the buffer full
        do_reset();
        for (int i = 0; i < 8; i++) rom[i] = 16'h0100 + 16'(i);
        rom[8] = 16'hFFFF;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0101);
        run = 1'b1;
        n = 0;
        while (!iin_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("drop_first_valid", {31'h0, iin_valid}, 32'h1);
        tick(2);
        pulse_done();
        tick(3);
        check("drop_pc_full", {24'h0, pc}, 32'h3);
        run = 1'b0;
        man_done = 1'b1;
        @(negedge clock);
        man_done = 1'b0;
        @(negedge clock);
        check("drop_pc_rewind", {24'h0, pc}, 32'h2);
        check("drop_valid", {31'h0, iin_valid}, 32'h0);
        for (int i = 2; i < 8; i++) exp_q.push_back(rom[i]);
        tgt_fix = 3; auto_done = 1'b1;
        run = 1'b1;
        end_scn("halt_drop", 200);

        // reset asserted during LOAD
        do_reset();
        rom[0] = 16'h5A5A;
        run = 1'b1;
        n = 0;
        while (!mem_en && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("rl_req_seen", {31'h0, mem_en}, 32'h1);
        @(posedge clock); #1;
        resetn = 1'b0;
        run = 1'b0;
        #1;
        check("rl_pc", {24'h0, pc}, 32'h0);
        check("rl_iin", {16'h0, iin}, 32'h0);
        check("rl_valid", {31'h0, iin_valid}, 32'h0);
        check("rl_mem_en", {31'h0, mem_en}, 32'h0);
        check("rl_mem_addr", {24'h0, mem_addr}, 32'h0);
        check("rl_halted", {31'h0, halted}, 32'h0);
        tick(2);
        resetn = 1'b1;
        tick(3);
        check("rl_stale_iin", {16'h0, iin}, 32'h0);
        check("rl_stale_valid", {31'h0, iin_valid}, 32'h0);

        // full pass over the ROM with PC wrap
        do_reset();
        for (int i = 0; i < 256; i++) rom[i] = rnd_word();
        for (int i = 0; i < 261; i++) exp_q.push_back(rom[i % 256]);
        req_next = 0; chk_req = 1'b1;
        tgt_fix = 0; auto_done = 1'b1;
        run = 1'b1;
        n = 0;
        while (pc < 8'd100 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        rom[5] = 16'hFFFF;
        end_scn("halt_wrap", 6000);
        check("wrap_req_count", 32'(req_next), 32'd6);
        chk_req = 1'b0;

        // random programs with random instruction lengths
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n = int'($urandom_range(30, 10));
            for (int i = 0; i < n; i++) begin
                rom[i] = rnd_word();
                exp_q.push_back(rom[i]);
            end
            rom[n] = 16'hFFFF;
            tgt_fix = 0; auto_done = 1'b1;
            run = 1'b1;
            end_scn("halt_rand", 400);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
